// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO status-FSM states and depth derivation.
//   fifo_state_e : EMPTY=2'b00, PARTIAL=2'b01, FULL=2'b10 (2'b11 illegal)
//   depth_of()   : FIFO depth for a given pointer width (2**width)
package fifo_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'b00,
      PARTIAL = 2'b01,
      FULL    = 2'b10
   } fifo_state_e;

   function automatic int depth_of(input int width);
      return 1 << width;
   endfunction

endpackage

// File: rtl/fifo_ptr_counter.sv
// fifo_ptr_counter: enable-gated wrapping pointer counter, async active-low reset.
//   clock   : rising-edge clock
//   reset   : asynchronous, active-low reset (count returns to 0)
//   en_i    : advance the pointer by one this cycle
//   count_o : current pointer, wraps modulo 2**WIDTH
module fifo_ptr_counter #(
   parameter int WIDTH = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] count_q;

   // Natural binary overflow provides the modulo-DEPTH wrap.
   always_ff @(posedge clock or negedge reset)
      if (!reset) count_q <= '0;
      else if (en_i) count_q <= count_q + WIDTH'(1);

   assign count_o = count_q;

endmodule

// File: rtl/fifo_read_status.sv
// fifo_read_status: FIFO read pointer, occupancy count, status FSM and error flags.
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   write_Enable        : raw write request (shared with the write-pointer stage)
//   read_Enable         : raw read request
//   sig_Full/sig_Empty  : occupancy status, decoded from registered count only
//   read_Pointer        : memory read address
//   fifo_Count          : occupancy 0..DEPTH
//   read_Valid          : memory read data valid (one cycle after accepted read)
//   fifo_State          : status FSM (EMPTY/PARTIAL/FULL)
//   overflow_Err        : sticky, write attempted while full
//   underflow_Err       : sticky, read attempted while empty
//   almost_Full/Empty   : present only when FIFO_ALMOST_FLAGS_EN is defined
module fifo_read_status
   import fifo_pkg::*;
#(
   parameter int BUFFER_WIDTH     = 3,
   parameter int ALMOST_FULL_LVL  = 6,
   parameter int ALMOST_EMPTY_LVL = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write_Enable,
   input  logic                  read_Enable,
   output logic                  sig_Full,
   output logic                  sig_Empty,
   output logic [BUFFER_WIDTH-1:0] read_Pointer,
   output logic [BUFFER_WIDTH:0]   fifo_Count,
   output logic                  read_Valid,
   output logic [1:0]            fifo_State,
   output logic                  overflow_Err,
`ifdef FIFO_ALMOST_FLAGS_EN
   output logic                  underflow_Err,
   output logic                  almost_Full,
   output logic                  almost_Empty
`else
   output logic                  underflow_Err
`endif
);

   localparam int DEPTH = depth_of(BUFFER_WIDTH);
   localparam int CW    = BUFFER_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   // Thresholds beyond the FIFO depth can never be reached; reject them early.
   if (ALMOST_FULL_LVL > DEPTH || ALMOST_EMPTY_LVL > DEPTH || ALMOST_FULL_LVL < 0 || ALMOST_EMPTY_LVL < 0) begin : g_lvl_check
      $error("fifo_read_status: almost thresholds out of range");
   end

   logic [CW-1:0] count_q, count_d;
   fifo_state_e   state_q, state_d;
   logic          valid_q, ovf_q, unf_q;
   logic          wr_acc, rd_acc;

   assign sig_Full  = (count_q == DEPTH_C);
   assign sig_Empty = (count_q == '0);
   // Same qualification as the write-pointer stage keeps both pointers in lock-step.
   assign wr_acc = write_Enable & ~sig_Full;
   assign rd_acc = read_Enable & ~sig_Empty;

   assign count_d = (wr_acc & ~rd_acc) ? count_q + CW'(1) :
                    (rd_acc & ~wr_acc) ? count_q - CW'(1) : count_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (wr_acc) state_d = PARTIAL;
         PARTIAL: if (wr_acc & ~rd_acc & (count_q == DEPTH_C - CW'(1))) state_d = FULL;
                  else if (rd_acc & ~wr_acc & (count_q == CW'(1))) state_d = EMPTY;
         FULL:    if (rd_acc) state_d = PARTIAL;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         count_q <= '0;
         state_q <= EMPTY;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         state_q <= state_d;
         valid_q <= rd_acc;
         ovf_q   <= ovf_q | (write_Enable & sig_Full);
         unf_q   <= unf_q | (read_Enable & sig_Empty);
      end

   fifo_ptr_counter #(.WIDTH(BUFFER_WIDTH)) u_rd_ptr (
      .clock  (clock),
      .reset  (reset),
      .en_i   (rd_acc),
      .count_o(read_Pointer)
   );

   assign fifo_Count    = count_q;
   assign fifo_State    = state_q;
   assign read_Valid    = valid_q;
   assign overflow_Err  = ovf_q;
   assign underflow_Err = unf_q;

`ifdef FIFO_ALMOST_FLAGS_EN
   assign almost_Full  = (count_q >= CW'(ALMOST_FULL_LVL));
   assign almost_Empty = (count_q <= CW'(ALMOST_EMPTY_LVL));
`endif

endmodule
